// File: rtl/parity_chk_pipe.sv
// Two-stage valid/ready pipeline that checks word parity in flight
// and keeps a sticky error flag plus a saturating error count.
module parity_chk_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4,
  parameter int ODD   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_par,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err,
  input  logic             clr,
  output logic             err_sticky,
  output logic [CNT_W-1:0] err_cnt
);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_data;
  logic             s1_par;

  logic s2_load;
  logic s1_load;
  logic accept;
  logic move;
  logic bad;
  logic move_bad;
  logic odd_bit;

  assign odd_bit  = (ODD != 0);
  assign s2_load  = !out_valid | out_ready;
  assign s1_load  = !s1_valid | s2_load;
  assign in_ready = s1_load;
  assign accept   = in_valid & in_ready;
  assign move     = s1_valid & s2_load;
  assign bad      = (^s1_data) ^ s1_par ^ odd_bit;
  assign move_bad = move & bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_par   <= 1'b0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_data  <= in_data;
      s1_par   <= in_par;
    end else if (move) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_err   <= 1'b0;
    end else if (move) begin
      out_valid <= 1'b1;
      out_data  <= s1_data;
      out_err   <= bad;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // clr wins over old state but never swallows an error arriving on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sticky <= 1'b0;
      err_cnt    <= '0;
    end else if (clr) begin
      err_sticky <= move_bad;
      err_cnt    <= move_bad ? CNT_W'(1) : '0;
    end else if (move_bad) begin
      err_sticky <= 1'b1;
      if (err_cnt != '1)
        err_cnt <= err_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_parity_chk_pipe.sv
// Directed bench for parity_chk_pipe: latency, parity flags, back-pressure,
// counter saturation, clear priority and mid-stream reset.
module tb_parity_chk_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_par;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_err;
  logic       clr;
  logic       err_sticky;
  logic [3:0] err_cnt;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  parity_chk_pipe #(.WIDTH(8), .CNT_W(4), .ODD(0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_par     (in_par),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_err    (out_err),
    .clr        (clr),
    .err_sticky (err_sticky),
    .err_cnt    (err_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic p);
    in_valid = v;
    in_data  = d;
    in_par   = p;
  endtask

  initial begin
    rst_n = 1'b0;
    out_ready = 1'b1;
    clr = 1'b0;
    drive(1'b0, 8'h00, 1'b0);

    // reset and idle
    #3;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_sticky", err_sticky, 0);
    check("rst_cnt", err_cnt, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_in_ready", in_ready, 1);
    check("idle_out_valid", out_valid, 0);

    // clean stream
    drive(1'b1, 8'h5C, 1'b0);
    @(negedge clk);
    check("clean_lat_valid", out_valid, 0);
    drive(1'b1, 8'h5D, 1'b1);
    @(negedge clk);
    check("clean1_valid", out_valid, 1);
    check("clean1_data", out_data, 8'h5C);
    check("clean1_err", out_err, 0);
    drive(1'b0, 8'h00, 1'b0);
    @(negedge clk);
    check("clean2_valid", out_valid, 1);
    check("clean2_data", out_data, 8'h5D);
    check("clean2_err", out_err, 0);
    check("clean_cnt", err_cnt, 0);
    @(negedge clk);
    check("clean_drain", out_valid, 0);

    // injected fault
    drive(1'b1, 8'h5C, 1'b1);
    @(negedge clk);
    drive(1'b0, 8'h00, 1'b0);
    check("fault_sticky_early", err_sticky, 0);
    check("fault_cnt_early", err_cnt, 0);
    @(negedge clk);
    check("fault_valid", out_valid, 1);
    check("fault_data", out_data, 8'h5C);
    check("fault_err", out_err, 1);
    check("fault_sticky", err_sticky, 1);
    check("fault_cnt", err_cnt, 1);
    @(negedge clk);

    // back-pressure
    out_ready = 1'b0;
    drive(1'b1, 8'h01, 1'b1);
    #1 check("bp_rdy1", in_ready, 1);
    @(negedge clk);
    drive(1'b1, 8'h02, 1'b1);
    #1 check("bp_rdy2", in_ready, 1);
    @(negedge clk);
    drive(1'b1, 8'h03, 1'b0);
    #1 check("bp_rdy3", in_ready, 0);
    @(negedge clk);
    check("bp_hold_rdy", in_ready, 0);
    check("bp_hold_valid", out_valid, 1);
    check("bp_hold_data", out_data, 8'h01);
    check("bp_hold_err", out_err, 0);
    out_ready = 1'b1;
    #1 check("bp_release_rdy", in_ready, 1);
    @(negedge clk);
    drive(1'b0, 8'h00, 1'b0);
    check("bp_out2_data", out_data, 8'h02);
    check("bp_out2_valid", out_valid, 1);
    @(negedge clk);
    check("bp_out3_data", out_data, 8'h03);
    check("bp_out3_err", out_err, 0);
    @(negedge clk);
    check("bp_drain", out_valid, 0);
    check("bp_cnt", err_cnt, 1);

    // saturation and clear
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr_cnt", err_cnt, 0);
    check("clr_sticky", err_sticky, 0);
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 8'h5C, 1'b1);
      @(negedge clk);
    end
    drive(1'b0, 8'h00, 1'b0);
    @(negedge clk);
    check("sat_cnt", err_cnt, 4'hF);
    check("sat_sticky", err_sticky, 1);
    @(negedge clk);
    drive(1'b1, 8'h5C, 1'b1);
    @(negedge clk);
    drive(1'b0, 8'h00, 1'b0);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr_bad_cnt", err_cnt, 1);
    check("clr_bad_sticky", err_sticky, 1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr_only_cnt", err_cnt, 0);
    check("clr_only_sticky", err_sticky, 0);

    // mid-stream reset
    out_ready = 1'b0;
    drive(1'b1, 8'hAA, 1'b0);
    @(negedge clk);
    drive(1'b1, 8'hBB, 1'b0);
    @(negedge clk);
    drive(1'b0, 8'h00, 1'b0);
    check("mid_full_rdy", in_ready, 0);
    check("mid_full_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_data", out_data, 0);
    check("mid_rst_err", out_err, 0);
    check("mid_rst_rdy", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mid_post_valid", out_valid, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
